// File: rtl/chamber_level.sv
// Chamber water-level controller: ramps a level counter between the downstream and
// upstream levels while both gates are closed, and shows the level on a 7-segment digit.
module chamber_level #(
  parameter int TICKS_PER_STEP = 4,
  parameter int LOW_LEVEL      = 0,
  parameter int HIGH_LEVEL     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       increaseEnable,
  input  logic       decreaseEnable,
  input  logic       gatesClosed,
  output logic [3:0] level,
  output logic       filling,
  output logic       draining,
  output logic       busy,
  output logic       done,
  output logic       leftGood,
  output logic       rightGood,
  output logic [6:0] seg
);

  localparam int             CW        = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CW-1:0]  LAST_TICK = CW'(TICKS_PER_STEP - 1);
  localparam logic [3:0]     LOW_L     = 4'(LOW_LEVEL);
  localparam logic [3:0]     HIGH_L    = 4'(HIGH_LEVEL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    level_q, level_d;
  logic          done_q, done_d;

  logic inc_only;
  logic dec_only;

  // Simultaneous requests cancel each other in every state.
  assign inc_only = increaseEnable & ~decreaseEnable;
  assign dec_only = decreaseEnable & ~increaseEnable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (inc_only && (level_q < HIGH_L)) begin
          state_d = FILL;
          cnt_d   = '0;
        end else if (dec_only && (level_q > LOW_L)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      FILL: begin
        // A reversal wins over a step landing on the same edge; level is untouched.
        if (dec_only) begin
          cnt_d   = '0;
          state_d = (level_q > LOW_L) ? DRAIN : IDLE;
        end else if (gatesClosed) begin
          if (cnt_q == LAST_TICK) begin
            cnt_d   = '0;
            level_d = level_q + 4'd1;
            if (level_d == HIGH_L) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (inc_only) begin
          cnt_d   = '0;
          state_d = (level_q < HIGH_L) ? FILL : IDLE;
        end else if (gatesClosed) begin
          if (cnt_q == LAST_TICK) begin
            cnt_d   = '0;
            level_d = level_q - 4'd1;
            if (level_d == LOW_L) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= LOW_L;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      done_q  <= done_d;
    end
  end

  assign level     = level_q;
  assign filling   = (state_q == FILL);
  assign draining  = (state_q == DRAIN);
  assign busy      = filling | draining;
  assign done      = done_q;
  assign leftGood  = (level_q == LOW_L);
  assign rightGood = (level_q == HIGH_L);

  // Active-low segments {g,f,e,d,c,b,a}.
  always_comb begin
    seg = 7'b1111111;
    case (level_q)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_chamber_level.sv
// Bench for chamber_level: per-cycle vector table with queued expectations,
// plus hand-written reset and mid-move reset sequences.
module tb_chamber_level;

  logic       clk;
  logic       reset;
  logic       increaseEnable;
  logic       decreaseEnable;
  logic       gatesClosed;
  logic [3:0] level;
  logic       filling;
  logic       draining;
  logic       busy;
  logic       done;
  logic       leftGood;
  logic       rightGood;
  logic [6:0] seg;

  chamber_level #(
    .TICKS_PER_STEP(4),
    .LOW_LEVEL     (0),
    .HIGH_LEVEL    (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .increaseEnable(increaseEnable),
    .decreaseEnable(decreaseEnable),
    .gatesClosed   (gatesClosed),
    .level         (level),
    .filling       (filling),
    .draining      (draining),
    .busy          (busy),
    .done          (done),
    .leftGood      (leftGood),
    .rightGood     (rightGood),
    .seg           (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       inc;
    logic       dec;
    logic       gates;
    int         n;
    logic [3:0] lvl;
    logic       fill;
    logic       drain;
    logic       dn;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] lvl;
    logic       fill;
    logic       drain;
    logic       dn;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_seen = 0;
  int   vec_no = 0;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;  default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic i, input logic d, input logic g, input int n,
                     input logic [3:0] l, input logic f, input logic dr, input logic dn);
    vec_t v;
    v.inc = i; v.dec = d; v.gates = g; v.n = n;
    v.lvl = l; v.fill = f; v.drain = dr; v.dn = dn;
    tbl.push_back(v);
  endtask

  // Outputs decoded purely from an expected level and state.
  task automatic chk_all(input string tag, input logic [3:0] l, input logic f,
                         input logic dr, input logic dn);
    chk({tag, " level"},     8'(level),     8'(l));
    chk({tag, " filling"},   8'(filling),   8'(f));
    chk({tag, " draining"},  8'(draining),  8'(dr));
    chk({tag, " busy"},      8'(busy),      8'(f | dr));
    chk({tag, " done"},      8'(done),      8'(dn));
    chk({tag, " leftGood"},  8'(leftGood),  8'(l == 4'd0));
    chk({tag, " rightGood"}, 8'(rightGood), 8'(l == 4'd5));
    chk({tag, " seg"},       8'(seg),       8'(glyph(l)));
  endtask

  task automatic run_vectors();
    exp_t e;
    foreach (tbl[k]) begin
      increaseEnable = tbl[k].inc;
      decreaseEnable = tbl[k].dec;
      gatesClosed    = tbl[k].gates;
      for (int c = 0; c < tbl[k].n; c++) begin
        if (c == tbl[k].n - 1) begin
          e.idx = vec_no; e.lvl = tbl[k].lvl; e.fill = tbl[k].fill;
          e.drain = tbl[k].drain; e.dn = tbl[k].dn;
          sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
      end
      e = sb.pop_front();
      chk_all($sformatf("vec%0d", e.idx), e.lvl, e.fill, e.drain, e.dn);
      $display("vec %0d: inc=%0b dec=%0b gates=%0b x%0d -> level=%0d fill=%0b drain=%0b done=%0b",
               e.idx, tbl[k].inc, tbl[k].dec, tbl[k].gates, tbl[k].n,
               level, filling, draining, done);
      vec_no++;
    end
    tbl.delete();
    increaseEnable = 1'b0;
    decreaseEnable = 1'b0;
    gatesClosed    = 1'b1;
  endtask

  initial begin
    reset = 1'b0; increaseEnable = 1'b0; decreaseEnable = 1'b0; gatesClosed = 1'b1;
    #1;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    $display("reset: level=%0d seg=%b", level, seg);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Full fill, ignored requests at the top
    add(1,0,1, 1, 0,1,0,0);  add(0,0,1, 3, 0,1,0,0);  add(0,0,1, 1, 1,1,0,0);
    add(0,0,1,15, 4,1,0,0);  add(0,0,1, 1, 5,0,0,1);  add(0,0,1, 1, 5,0,0,0);
    add(1,0,1, 1, 5,0,0,0);  add(1,1,1, 1, 5,0,0,0);  add(0,0,1, 2, 5,0,0,0);
    // Full drain, ignored request at the bottom
    add(0,1,1, 1, 5,0,1,0);  add(0,0,1,19, 1,0,1,0);  add(0,0,1, 1, 0,0,0,1);
    add(0,0,1, 1, 0,0,0,0);  add(0,1,1, 1, 0,0,0,0);
    // Fill with a 3-cycle gate freeze at level 2: completes at edge 23
    add(1,0,1, 1, 0,1,0,0);  add(0,0,1, 8, 2,1,0,0);  add(0,0,0, 3, 2,1,0,0);
    add(0,0,1, 3, 2,1,0,0);  add(0,0,1, 1, 3,1,0,0);  add(0,0,1, 7, 4,1,0,0);
    add(0,0,1, 1, 5,0,0,1);  add(0,0,1, 1, 5,0,0,0);
    // Drain reversed to fill at level 3, with ignored requests mid-move
    add(0,1,1, 1, 5,0,1,0);  add(0,0,1, 8, 3,0,1,0);  add(1,0,1, 1, 3,1,0,0);
    add(1,0,1, 1, 3,1,0,0);  add(0,0,1, 2, 3,1,0,0);  add(0,0,1, 1, 4,1,0,0);
    add(1,1,1, 1, 4,1,0,0);  add(0,0,1, 2, 4,1,0,0);  add(0,0,1, 1, 5,0,0,1);
    add(0,0,1, 1, 5,0,0,0);
    run_vectors();

    // Mid-move reset: drain from 5, reset between edges at level 3
    decreaseEnable = 1'b1;
    @(posedge clk); @(negedge clk);
    decreaseEnable = 1'b0;
    repeat (8) begin @(posedge clk); @(negedge clk); end
    chk_all("premid", 4'd3, 1'b0, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_all("midreset", 4'd0, 1'b0, 1'b0, 1'b0);
    $display("midreset: level=%0d busy=%0b done=%0b", level, busy, done);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;

    // After release: drain ignored at 0, then fill reversed to drain at level 2
    add(0,1,1, 1, 0,0,0,0);  add(1,0,1, 1, 0,1,0,0);  add(0,0,1, 8, 2,1,0,0);
    add(0,1,1, 1, 2,0,1,0);  add(0,0,1, 3, 2,0,1,0);  add(0,0,1, 1, 1,0,1,0);
    add(0,0,1, 3, 1,0,1,0);  add(0,0,1, 1, 0,0,0,1);  add(0,0,1, 1, 0,0,0,0);
    run_vectors();

    chk("done_pulse_total", 8'(done_seen), 8'd5);
    chk("scoreboard_empty", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chamber_level.md
# chamber_level

Water-level controller for the pound lock chamber. It sits directly downstream of the lock input controller and consumes that controller's `increaseEnable`/`decreaseEnable` pulses. It ramps a chamber level counter between the downstream (low) and upstream (high) water levels at a fixed rate, and only while both gates are closed. It reports the level on one 7-segment digit (HEX0) and flags level equalization back to the controller (`leftGood`/`rightGood`).

## Interface
- `TICKS_PER_STEP`, default 4: clock cycles per one-unit level change; ≥1.
- `LOW_LEVEL`, default 0: downstream water level.
- `HIGH_LEVEL`, default 5: upstream water level; LOW_LEVEL < HIGH_LEVEL ≤ 15.

- `clk`  in  1  system clock (divided clock at top level).
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `increaseEnable`  in  1  one-cycle fill request.
- `decreaseEnable`  in  1  one-cycle drain request.
- `gatesClosed`  in  1  1 = both gates closed; level may only move while 1.
- `level`  out  4  current chamber level.
- `filling`  out  1  state is FILL.
- `draining`  out  1  state is DRAIN.
- `busy`  out  1  filling | draining.
- `done`  out  1  one-cycle pulse when a fill or drain completes.
- `leftGood`  out  1  level == LOW_LEVEL.
- `rightGood`  out  1  level == HIGH_LEVEL.
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a} showing `level` as a hex digit 0–F.

## Operation
- State machine states are IDLE, FILL and DRAIN. There is a tick counter of width max(1, clog2(TICKS_PER_STEP)).
- **IDLE:**
  - increaseEnable=1, decreaseEnable=0, level<HIGH_LEVEL → FILL, counter←0.
  - decreaseEnable=1, increaseEnable=0, level>LOW_LEVEL → DRAIN, counter←0.
  - Both requests set, or the request is already satisfied → stay IDLE; no done pulse.
- **FILL / DRAIN, gatesClosed=1:**
  - The counter increments each cycle.
  - At counter==TICKS_PER_STEP-1: counter←0 and level±1.
  - If the new level equals the target (HIGH for FILL, LOW for DRAIN): → IDLE and done←1.
- **FILL / DRAIN, gatesClosed=0:** counter, level and state all hold (frozen).
- **Reversal:** an opposite-direction request alone in FILL/DRAIN switches state (FILL↔DRAIN) with counter←0. Level is unchanged on the switch cycle.
- **Ignored requests in FILL/DRAIN:** a same-direction request, or both requests at once, is ignored.
- **Combinational outputs:** `filling`, `draining`, `busy`, `leftGood`, `rightGood` and `seg` decode from registered state and level.
- **Registered outputs:** `done` is registered and high for exactly one cycle.
- **Arithmetic:** level never leaves [LOW_LEVEL, HIGH_LEVEL]. No wrap is possible because moves stop at the target.
- **seg glyphs:** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

## Timing
- **Reset values** (immediately on reset=0, independent of clk):
  - state IDLE, counter 0, level=LOW_LEVEL, done 0.
  - filling/draining/busy 0.
  - leftGood 1, rightGood 0.
  - seg shows the LOW_LEVEL glyph.
- **Request sampling:** requests are sampled on the clk rising edge k. filling/draining is high after edge k.
- **Step timing:** the first level step happens at edge k+TICKS_PER_STEP, assuming gatesClosed stays 1.
- **Full move:** completes at edge k+(HIGH_LEVEL−LOW_LEVEL)·TICKS_PER_STEP. After that edge: state IDLE, done=1 for one cycle, and the matching leftGood/rightGood=1.
- **Gate freeze:** each cycle with gatesClosed=0 while busy delays completion by exactly one cycle.
- **Reversal timing:** a reversal at edge r gives the first step at edge r+TICKS_PER_STEP.
- **Requests on the completion edge:** these are evaluated against the pre-edge state (FILL/DRAIN rules), not IDLE.
- **Mid-move reset:** reset asserted mid-move aborts the move and restores the reset values. Deassertion is synchronized externally; the first active edge after deassertion behaves as IDLE.

## Test plan
(TICKS_PER_STEP=4, LOW=0, HIGH=5.)
1. **Reset:** reset=0 → level=0, leftGood=1, rightGood=0, busy=0, seg=1000000.
2. **Fill:** increaseEnable pulse with gatesClosed=1 → filling=1 next cycle; level=1 after 4 edges; level=5 after 20 edges. done high for 1 cycle, rightGood=1, seg=0010010.
3. **Gate freeze:** repeat 2, but drop gatesClosed for 3 cycles at level 2 → level and counter hold; completion occurs at edge 23; done still a single pulse.
4. **Ignored requests:** at level 5, increaseEnable → stays IDLE, no done. increaseEnable and decreaseEnable together → stays IDLE.
5. **Reversal:** fill from 0, at level 2 pulse decreaseEnable → draining=1, filling=0; level=1 four edges later, level=0 eight edges later; done pulse, leftGood=1.
6. **Mid-move reset:** drain from 5, assert reset=0 at level 3 between clock edges → level=0, busy=0, done=0 immediately. After release, decreaseEnable is ignored because level is already 0.
